l2_write_buffer: RTL and testbench
==================================

Name: l2_write_buffer

Overview:
- Eviction write buffer between the L2 cache's physical-memory port and the cacheline adaptor.
- Absorbs dirty-line writebacks from L2 so that L2 refills are not blocked behind writebacks.
- Drains buffered lines to memory in the background when the L2 side is idle.
- Forwards buffered data on L2 read hits, so the buffer always holds the newest copy of any line it contains.

Parameters:
- DEPTH, 4, number of 256-bit line entries (power of two, 2..16).
- LINE_W, 256, cacheline width in bits.
- OFFSET_BITS, 5, line-offset bits ignored for address match and alignment.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pmem_read  in  1  L2 line-read request, held until pmem_resp.
- pmem_write  in  1  L2 line-writeback request, held until pmem_resp.
- pmem_address  in  32  L2 request address.
- pmem_wdata  in  LINE_W  writeback line.
- pmem_rdata  out  LINE_W  read line, valid while pmem_resp is high.
- pmem_resp  out  1  single-cycle completion pulse to L2.
- read_o  out  1  line read to the cacheline adaptor.
- write_o  out  1  line write to the cacheline adaptor.
- address_o  out  32  line-aligned downstream address.
- line_o  out  LINE_W  downstream write line.
- line_i  in  LINE_W  downstream read line.
- resp_i  in  1  single-cycle downstream completion pulse.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. Reset applies at the clock edge where rst is high.
- Reset values: all outputs 0, all entries invalid, count 0, state IDLE.
- Reset mid-operation: any in-flight transaction is abandoned; the adaptor shares the same rst.
- Storage:
  - DEPTH-entry circular FIFO, each entry {valid, tag = address[31:OFFSET_BITS], line}.
  - Head and tail pointers wrap modulo DEPTH.
  - Count ranges 0..DEPTH.
- Line match: a tag compare against all valid entries. At most one entry matches any given tag.
- States: IDLE, UP_RESP, DRAIN, FETCH.
- IDLE priority, evaluated each cycle:
  - (1) upstream write,
  - (2) upstream read,
  - (3) drain if count > 0,
  - (4) stay.
  - If pmem_read and pmem_write are both high (illegal), the write is served.
- Write in IDLE at cycle t:
  - Matching entry: overwrite its line in place (coalesce); FIFO position is unchanged. Go to UP_RESP.
  - No match and count < DEPTH: push at tail, count+1. Go to UP_RESP.
  - No match and count == DEPTH: go to DRAIN. The write is re-evaluated on return to IDLE.
- Read in IDLE at cycle t:
  - Matching entry: capture its line into the pmem_rdata register. Go to UP_RESP.
  - No match: go to FETCH.
- UP_RESP: pmem_resp = 1 for exactly one cycle (t+1). pmem_rdata is valid in that cycle for reads. Next state is IDLE.
- DRAIN:
  - Outputs: write_o = 1, address_o = {head tag, OFFSET_BITS zeros}, line_o = head line. These stay stable until resp_i.
  - On resp_i: invalidate head, head+1, count-1, write_o = 0 next cycle, go to IDLE.
  - A drain in progress always completes before any upstream request is served.
- FETCH:
  - Outputs: read_o = 1, address_o = pmem_address with the offset bits zeroed, held until resp_i.
  - On resp_i: capture line_i, go to UP_RESP. pmem_resp therefore arrives one cycle after resp_i.
- Downstream handshake:
  - At most one downstream transaction outstanding.
  - read_o and write_o are never high together.
  - read_o and write_o are registered outputs.
- Latency:
  - Write accepted with space: pmem_resp at t+1.
  - Read hit: pmem_resp at t+1.
  - Read miss: pmem_resp at resp_i+1.
- Drain order: FIFO (oldest first). A coalesced entry drains once, with its latest data.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined: read hits are forwarded from the buffer as described in Behaviour.
- Undefined:
  - A read matching any valid entry forces DRAIN repeatedly until count == 0.
  - The read is then served via FETCH.
  - Reads that match no entry follow the normal miss path.
- Write behaviour is identical in both builds.

Test Plan:
- Empty buffer; write 0x0000_1000 with D1 at t → pmem_resp at t+1; next idle cycle shows write_o=1, address_o=0x0000_1000, line_o=D1; after resp_i, count=0.
- Writes to 0x1000, 0x2000, 0x3000, 0x4000 back-to-back, then write 0x5000 → no pmem_resp until 0x1000 drains via resp_i; then 0x5000 accepted, count=4.
- Write 0x2000 with D1, then write 0x2010 with D2 → count=1; a single downstream write to 0x2000 carrying D2.
- Write 0x3000 with D3, then read 0x3004 → pmem_rdata=D3 and pmem_resp one cycle after the read is sampled; read_o stays 0. With WB_FORWARD_EN undefined: write_o for 0x3000, then read_o for 0x3000.
- Read miss 0x4008, adaptor returns M → read_o with address_o=0x4000; pmem_rdata=M and pmem_resp one cycle after resp_i.
- Assert rst during DRAIN with count=3 → next cycle all outputs 0, count 0; a subsequent read of the drained address misses.

Source files
------------

// File: rtl/l2_write_buffer.sv
// Eviction write buffer between the L2 pmem port and the cacheline adaptor.
// Define WB_FORWARD_EN to serve read hits from the buffer instead of flushing it first.
module l2_write_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LINE_W      = 256,
  parameter int unsigned OFFSET_BITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              read_o,
  output logic              write_o,
  output logic [31:0]       address_o,
  output logic [LINE_W-1:0] line_o,
  input  logic [LINE_W-1:0] line_i,
  input  logic              resp_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TagW = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {StIdle, StUpResp, StDrain, StFetch} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  valid_q;
  logic [TagW-1:0]   ent_tag_q  [DEPTH];
  logic [LINE_W-1:0] ent_line_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic              flush_q, flush_d;
  logic [LINE_W-1:0] rdata_q;
  logic              read_q, write_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wline_q;

  logic [TagW-1:0] req_tag;
  logic            hit;
  logic [PtrW-1:0] hit_idx;
  logic            full;
  logic            coal_en, push_en, pop_en, fwd_en, fill_en;
  logic            start_drain, start_fetch;
  logic            unused_addr_bits;

  assign req_tag          = pmem_address[31:OFFSET_BITS];
  assign unused_addr_bits = ^pmem_address[OFFSET_BITS-1:0];
  assign full             = (count_q == CntW'(DEPTH));

  // Tags are unique among valid entries, so at most one bit can fire.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (ent_tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PtrW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    coal_en     = 1'b0;
    push_en     = 1'b0;
    pop_en      = 1'b0;
    fwd_en      = 1'b0;
    fill_en     = 1'b0;
    start_drain = 1'b0;
    start_fetch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pmem_write) begin
          if (hit) begin
            coal_en = 1'b1;
            state_d = StUpResp;
          end else if (!full) begin
            push_en = 1'b1;
            state_d = StUpResp;
          end else begin
            start_drain = 1'b1;
            state_d     = StDrain;
          end
        end else if (pmem_read) begin
`ifdef WB_FORWARD_EN
          if (hit) begin
            fwd_en  = 1'b1;
            state_d = StUpResp;
          end else begin
            start_fetch = 1'b1;
            state_d     = StFetch;
          end
`else
          // A hit commits us to emptying the whole buffer before fetching.
          if ((hit || flush_q) && (count_q != '0)) begin
            flush_d     = 1'b1;
            start_drain = 1'b1;
            state_d     = StDrain;
          end else begin
            flush_d     = 1'b0;
            start_fetch = 1'b1;
            state_d     = StFetch;
          end
`endif
        end else if (count_q != '0) begin
          start_drain = 1'b1;
          state_d     = StDrain;
        end
      end
      StUpResp: state_d = StIdle;
      StDrain: begin
        if (resp_i) begin
          pop_en  = 1'b1;
          state_d = StIdle;
        end
      end
      StFetch: begin
        if (resp_i) begin
          fill_en = 1'b1;
          state_d = StUpResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (coal_en) begin
        ent_line_q[hit_idx] <= pmem_wdata;
      end
      if (push_en) begin
        valid_q[tail_q]    <= 1'b1;
        ent_tag_q[tail_q]  <= req_tag;
        ent_line_q[tail_q] <= pmem_wdata;
        tail_q             <= tail_q + PtrW'(1);
        count_q            <= count_q + CntW'(1);
      end
      if (pop_en) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
        count_q         <= count_q - CntW'(1);
        write_q         <= 1'b0;
      end
      // Snapshot the head so address_o/line_o stay stable for the whole drain.
      if (start_drain) begin
        write_q <= 1'b1;
        addr_q  <= {ent_tag_q[head_q], {OFFSET_BITS{1'b0}}};
        wline_q <= ent_line_q[head_q];
      end
      if (start_fetch) begin
        read_q <= 1'b1;
        addr_q <= {req_tag, {OFFSET_BITS{1'b0}}};
      end
      if (fill_en) begin
        read_q  <= 1'b0;
        rdata_q <= line_i;
      end
      if (fwd_en) begin
        rdata_q <= ent_line_q[hit_idx];
      end
    end
  end

  assign pmem_resp  = (state_q == StUpResp);
  assign pmem_rdata = rdata_q;
  assign read_o     = read_q;
  assign write_o    = write_q;
  assign address_o  = addr_q;
  assign line_o     = wline_q;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench for l2_write_buffer: a reference FIFO model predicts drains and read data,
// and a behavioural adaptor with variable latency backs the downstream port.
module tb_l2_write_buffer;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned LINE_W      = 256;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned TagW        = 32 - OFFSET_BITS;

  typedef logic [LINE_W-1:0] line_t;
  typedef struct {
    logic [TagW-1:0] tag;
    line_t           line;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  line_t       pmem_wdata, pmem_rdata;
  logic        pmem_resp;
  logic        read_o, write_o;
  logic [31:0] address_o;
  line_t       line_o, line_i;
  logic        resp_i;

  l2_write_buffer #(
    .DEPTH(DEPTH),
    .LINE_W(LINE_W),
    .OFFSET_BITS(OFFSET_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .read_o(read_o),
    .write_o(write_o),
    .address_o(address_o),
    .line_o(line_o),
    .line_i(line_i),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  ent_t        model[$];
  line_t       mem[logic [31:0]];
  line_t       rd_exp[$];
  int          dw_cnt = 0;
  int          saw_read = 0;
  int unsigned last_resp_cyc = 0;
  int unsigned rd_resp_cyc = 0;
  int          adapt_lat = 2;
  logic [31:0] rd_addr_exp = '0;
  bit          adp_busy = 1'b0;
  int          adp_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic line_t mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic line_t pat(input int k);
    logic [31:0] kk;
    kk = 32'hD000_0000 + k;
    return {4{kk, ~kk}};
  endfunction

  function automatic int find(input logic [TagW-1:0] t);
    for (int i = 0; i < model.size(); i++) if (model[i].tag == t) return i;
    return -1;
  endfunction

  // Behavioural cacheline adaptor: drives resp_i for one cycle after adp_lat idle cycles.
  initial begin
    ent_t e;
    resp_i = 1'b0;
    line_i = '0;
    forever begin
      @(negedge clk);
      resp_i = 1'b0;
      if (rst) begin
        adp_busy = 1'b0;
      end else if (!adp_busy) begin
        if (read_o || write_o) begin
          adp_busy = 1'b1;
          adp_lat  = adapt_lat;
          check_eq("rd_wr_excl", line_t'(read_o && write_o), line_t'(0));
        end
      end else if (!(read_o || write_o)) begin
        adp_busy = 1'b0;
      end else if (adp_lat > 0) begin
        adp_lat--;
      end else begin
        adp_busy = 1'b0;
        if (write_o) begin
          if (model.size() == 0) begin
            check_eq("dw_unexpected", line_t'(1), line_t'(0));
          end else begin
            e = model.pop_front();
            check_eq("dw_addr", line_t'(address_o), line_t'({e.tag, {OFFSET_BITS{1'b0}}}));
            check_eq("dw_line", line_o, e.line);
          end
          mem[address_o] = line_o;
          dw_cnt++;
        end else begin
          check_eq("dr_addr", line_t'(address_o), line_t'(rd_addr_exp));
          line_i = mem_rd(address_o);
          saw_read++;
          last_resp_cyc = cyc;
        end
        resp_i = 1'b1;
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input line_t d, output int lat);
    int idx;
    pmem_address = a;
    pmem_wdata   = d;
    pmem_write   = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (pmem_resp || lat >= 300) break;
    end
    pmem_write = 1'b0;
    if (!pmem_resp) begin
      check_eq("wr_timeout", line_t'(0), line_t'(1));
    end else begin
      idx = find(a[31:OFFSET_BITS]);
      if (idx >= 0) model[idx].line = d;
      else model.push_back('{tag: a[31:OFFSET_BITS], line: d});
    end
  endtask

  task automatic do_read(input logic [31:0] a, output int lat);
    int          idx;
    logic [31:0] al;
    al  = {a[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    idx = find(a[31:OFFSET_BITS]);
    rd_exp.push_back(idx >= 0 ? model[idx].line : mem_rd(al));
    rd_addr_exp  = al;
    pmem_address = a;
    pmem_read    = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (pmem_resp || lat >= 300) break;
    end
    pmem_read   = 1'b0;
    rd_resp_cyc = cyc;
    if (!pmem_resp) begin
      check_eq("rd_timeout", line_t'(0), line_t'(1));
      void'(rd_exp.pop_front());
    end else begin
      check_eq("rd_data", pmem_rdata, rd_exp.pop_front());
    end
  endtask

  task automatic wait_drained();
    int n = 0;
    while (model.size() != 0 || write_o || adp_busy) begin
      @(negedge clk);
      n++;
      if (n >= 500) begin
        check_eq("drain_timeout", line_t'(model.size()), line_t'(0));
        return;
      end
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_resp"}, line_t'(pmem_resp), line_t'(0));
    check_eq({pfx, "_read_o"}, line_t'(read_o), line_t'(0));
    check_eq({pfx, "_write_o"}, line_t'(write_o), line_t'(0));
    check_eq({pfx, "_address_o"}, line_t'(address_o), line_t'(0));
    check_eq({pfx, "_line_o"}, line_o, line_t'(0));
    check_eq({pfx, "_rdata"}, pmem_rdata, line_t'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dw0, rd0, n;
    logic [31:0] a;
    rst = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single write into an empty buffer, then background drain.
    dw0 = dw_cnt;
    do_write(32'h0000_1000, pat(1), lat);
    check_eq("w1_lat", line_t'(lat), line_t'(1));
    wait_drained();
    check_eq("w1_drains", line_t'(dw_cnt - dw0), line_t'(1));

    // Fill the buffer back-to-back; the fifth write must wait for the oldest drain.
    for (int i = 0; i < 4; i++) begin
      do_write(32'h0000_1000 * (i + 1), pat(10 + i), lat);
      check_eq("fill_lat", line_t'(lat), line_t'(i == 0 ? 1 : 2));
    end
    dw0 = dw_cnt;
    do_write(32'h0000_5000, pat(14), lat);
    check_eq("full_stall", line_t'(lat > 2), line_t'(1));
    check_eq("full_one_drain", line_t'(dw_cnt - dw0), line_t'(1));
    check_eq("full_count", line_t'(model.size()), line_t'(DEPTH));
    wait_drained();

    // Coalescing: two writes to the same line produce a single downstream write.
    dw0 = dw_cnt;
    do_write(32'h0000_2000, pat(20), lat);
    do_write(32'h0000_2010, pat(21), lat);
    check_eq("coal_count", line_t'(model.size()), line_t'(1));
    wait_drained();
    check_eq("coal_drains", line_t'(dw_cnt - dw0), line_t'(1));

    // Read hit on a buffered line.
    dw0 = dw_cnt;
    rd0 = saw_read;
    do_write(32'h0000_3000, pat(30), lat);
    do_read(32'h0000_3004, lat);
`ifdef WB_FORWARD_EN
    check_eq("hit_lat", line_t'(lat), line_t'(2));
    check_eq("hit_no_read", line_t'(saw_read - rd0), line_t'(0));
`else
    check_eq("hit_flush", line_t'(dw_cnt - dw0), line_t'(1));
    check_eq("hit_fetch", line_t'(saw_read - rd0), line_t'(1));
`endif
    wait_drained();

    // Read miss goes downstream; pmem_resp follows resp_i by one cycle.
    rd0 = saw_read;
    do_read(32'h0000_4008, lat);
    check_eq("miss_fetch", line_t'(saw_read - rd0), line_t'(1));
    check_eq("miss_lat", line_t'(rd_resp_cyc - last_resp_cyc), line_t'(1));

    // Reset in the middle of a drain with three entries buffered.
    adapt_lat = 20;
    do_write(32'h0000_7000, pat(70), lat);
    do_write(32'h0000_8000, pat(80), lat);
    do_write(32'h0000_9000, pat(90), lat);
    n = 0;
    while (!write_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_drain_started", line_t'(write_o), line_t'(1));
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    adapt_lat = 2;
    @(negedge clk);
    rd0 = saw_read;
    do_read(32'h0000_7000, lat);
    check_eq("rst_read_miss", line_t'(saw_read - rd0), line_t'(1));

    // Random mix over a few lines with varying adaptor latency.
    for (int i = 0; i < 80; i++) begin
      adapt_lat = $urandom_range(0, 3);
      a = 32'h0001_0000 + ($urandom_range(0, 5) << OFFSET_BITS) + $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) do_write(a, pat(100 + i), lat);
      else do_read(a, lat);
      n = $urandom_range(0, 3);
      repeat (n) @(negedge clk);
    end
    wait_drained();
    check_eq("final_empty", line_t'(model.size()), line_t'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
